// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside execute.
// Radix-2 shift-add multiply, restoring divide, WIDTH iterations.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_neg;
  logic               w_div0;
  logic               w_ovf;
  logic               w_fast;
  logic [WIDTH-1:0]   w_fast_res;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ok;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_res;

  // r_a/r_b hold raw operands after IDLE, magnitudes from PREP on
  assign w_a_signed = r_op[2] ? !r_op[0]
                    : (r_op[1:0] == 2'd1) || (r_op[1:0] == 2'd2);
  assign w_b_signed = r_op[2] ? !r_op[0] : (r_op[1:0] == 2'd1);
  assign w_sa       = w_a_signed & r_a[WIDTH-1];
  assign w_sb       = w_b_signed & r_b[WIDTH-1];
  assign w_mag_a    = w_sa ? -r_a : r_a;
  assign w_mag_b    = w_sb ? -r_b : r_b;
  assign w_neg      = (r_op[2] && r_op[1]) ? w_sa : (w_sa ^ w_sb);

  assign w_div0 = (r_b == '0);
  assign w_ovf  = !r_op[0] && (r_b == '1)
               && (r_a == {1'b1, {(WIDTH-1){1'b0}}});
  assign w_fast = r_op[2] && (w_div0 || w_ovf);
  assign w_fast_res = w_div0 ? (r_op[1] ? r_a : '1)
                             : (r_op[1] ? '0 : r_a);

  assign w_addend = r_b[0] ? r_a : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

  // Dividend bits shift out of r_a MSB; quotient bits enter at LSB
  assign w_trial = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_diff  = {1'b0, w_trial} - {2'b00, r_b};
  assign w_ok    = !w_diff[WIDTH+1];

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_a : r_a;
  assign w_rem  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  always_comb begin
    w_fix_res = '0;
    unique case (r_op)
      3'd0:             w_fix_res = w_prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       w_fix_res = w_quo;
      3'd6, 3'd7:       w_fix_res = w_rem;
      default:          w_fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op    <= op;
            r_a     <= operand_a;
            r_b     <= operand_b;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_acc <= '0;
          r_cnt <= '0;
          r_a   <= w_mag_a;
          r_b   <= w_mag_b;
          r_neg <= w_neg;
          if (w_fast) begin
            r_result <= w_fast_res;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_op[2]) begin
            r_acc <= {{(WIDTH-1){1'b0}},
                      (w_ok ? w_diff[WIDTH:0] : w_trial)};
            r_a   <= {r_a[WIDTH-2:0], w_ok};
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            r_b   <= r_b >> 1;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Combinational on start so execute stalls in the request cycle
  assign stall_out = (start && !abort && (r_state == S_IDLE))
                  || (r_state == S_PREP)
                  || (r_state == S_RUN)
                  || (r_state == S_FIX);
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer.
// Results compared against a 64-bit arithmetic reference.
module tb_muldiv_sequencer;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        stall_out;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_chk;
  int n_fail;

  muldiv_sequencer #(.WIDTH(32)) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .abort     (abort),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .stall_out (stall_out),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 0;
    u  = '0;
    case (o)
      3'd0: p = ua * ub;
      3'd1: p = (sa * sb) >>> 32;
      3'd2: p = (sa * ub) >>> 32;
      3'd3: begin
        u = {32'd0, a} * {32'd0, b};
        p = longint'(u >> 32);
      end
      3'd4: p = (b == 0) ? -1 : sa / sb;
      3'd5: p = (b == 0) ? -1 : ua / ub;
      3'd6: p = (b == 0) ? sa : sa % sb;
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic bit is_fast(input logic [2:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    return o[2] && ((b == 0) ||
      (!o[0] && a == 32'h8000_0000 && b == 32'hffff_ffff));
  endfunction

  task automatic run_op(input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    int lat;
    int k;
    int nst;
    exp = ref_model(o, a, b);
    lat = is_fast(o, a, b) ? 1 : 34;
    @(negedge clk);
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    #1 chk("stall_req", 32'(stall_out), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    nst = 0;
    while (!done && k < 40) begin
      if (stall_out) nst++;
      @(posedge clk);
      #1 k++;
    end
    chk("latency", 32'(k), 32'(lat));
    chk("stall_cycles", 32'(nst), 32'(lat));
    chk("stall_in_done", 32'(stall_out), 32'd0);
    chk("result", result, exp);
    @(posedge clk);
    #1 chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prev;
    int ndone;
    n_chk = 0;
    n_fail = 0;
    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    op = '0;
    operand_a = '0;
    operand_b = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op(3'd0, 32'd7, 32'hffff_fffd);
    run_op(3'd3, 32'hffff_ffff, 32'hffff_ffff);
    run_op(3'd1, 32'hffff_ffff, 32'hffff_ffff);
    run_op(3'd2, 32'hffff_ffff, 32'd2);
    run_op(3'd4, 32'hffff_fff9, 32'd2);
    run_op(3'd6, 32'hffff_fff9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd5, 32'h1234, 32'd0);
    run_op(3'd7, 32'h1234, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hffff_ffff);
    run_op(3'd6, 32'h8000_0000, 32'hffff_ffff);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);

    // abort while RUN counter is 10
    prev = result;
    ndone = 0;
    @(negedge clk);
    op = 3'd0;
    operand_a = 32'h1234;
    operand_b = 32'h5678;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_stall", 32'(stall_out), 32'd0);
    chk("abort_done", 32'(done | (ndone != 0)), 32'd0);
    chk("abort_result", result, prev);
    run_op(3'd0, 32'd3, 32'd5);

    // start and abort together in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    op = 3'd0;
    #1 chk("sa_stall", 32'(stall_out), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 chk("sa_busy2", 32'(busy), 32'd0);
    chk("sa_result", result, 32'd15);

    // reset in the middle of RUN
    @(negedge clk);
    op = 3'd5;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1 chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_stall", 32'(stall_out), 32'd0);
    chk("mrst_result", result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // second start while busy is ignored
    ndone = 0;
    @(negedge clk);
    op = 3'd3;
    operand_a = 32'hffff_ffff;
    operand_b = 32'hffff_ffff;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) begin
        op = 3'd5;
        operand_a = 32'd100;
        operand_b = 32'd7;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 if (done) begin
        ndone++;
        chk("busy_ign_res", result, 32'hffff_fffe);
      end
    end
    start = 1'b0;
    chk("busy_ign_ndone", 32'(ndone), 32'd1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      run_op(o, pick(), pick());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide controller that sits beside the execute stage.
- Accepts one operation per start pulse and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- Drives a stall request into the hazard unit while running, then presents the result for one cycle so execute can capture it into alu_data_out.
- Pipeline invalidate aborts it.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
start  input  1  request new operation (decode valid && muldiv op && !invalidate)
abort  input  1  from hazard invalidate; cancels any operation
op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
operand_a  input  WIDTH  rs1 data
operand_b  input  WIDTH  rs2 data
stall_out  output  1  to hazard unit; holds pipeline until result ready
busy  output  1  state != IDLE
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  selected product half, quotient or remainder

Behaviour:
- Reset (async, resetn=0): state=IDLE, done=0, busy=0, result=0, counter=0, internal accumulators=0. Reset mid-operation discards the operation; no done.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - start && !abort latches op and operands → PREP.
  - start is ignored in every other state.
- PREP (1 cycle):
  - Computes operand magnitudes for signed ops: MULH both signed, MULHSU a only, DIV/REM both.
  - Records result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Clears the 2*WIDTH accumulator and counter.
  - Fast path → DONE directly:
    - divisor 0: DIV/DIVU give all-ones; REM/REMU give operand_a.
    - DIV/REM with a = 0x80000000 and b = 0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
  - Otherwise → RUN.
- RUN (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: one multiplier bit per cycle, LSB first, add-and-shift into the 2*WIDTH accumulator.
  - Divide: one quotient bit per cycle, MSB first. Shift the remainder left with the next dividend bit, trial-subtract the magnitude divisor, keep the subtraction if it is non-negative and set the quotient bit.
  - At counter = WIDTH-1 → FIX.
- FIX (1 cycle):
  - Applies two's-complement negation per the recorded sign to the full 2*WIDTH product or to quotient/remainder.
  - Selects into result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
  - → DONE.
- DONE (1 cycle):
  - done=1, result valid; → IDLE.
  - result register holds its value until the next PREP/FIX update.
- Latency, with start sampled at edge E0:
  - normal op: done high in the cycle after edge E0+34;
  - fast path: done high in the cycle after E0+1.
- stall_out = (start && !abort && state==IDLE) || state ∈ {PREP, RUN, FIX}.
  - stall_out is low in DONE so execute advances and captures result that cycle.
  - Combinational from start, so execute is stalled in the same cycle as the request.
- Abort:
  - In any state, abort=1 at an edge → IDLE; done is not asserted; result keeps its old value.
  - start and abort in the same cycle: abort wins, nothing is latched.
- busy is a registered decode of state; done is registered (high only in DONE).
- Back-to-back: start is accepted in the IDLE cycle directly following DONE. No start accepted during DONE itself.
- Signed arithmetic:
  - magnitude of 0x80000000 is 0x80000000, treated as unsigned WIDTH bits;
  - the accumulator is WIDTH+1 bits wide for the divide trial subtraction.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD (-3) → result 0xFFFFFFEB; done exactly 34 cycles after start edge; stall_out high for those 34 cycles, low in the done cycle.
2. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
3. DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
4. DIVU 0x1234/0 → 0xFFFFFFFF and REMU 0x1234/0 → 0x1234, done 1 cycle after start edge. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, same fast latency.
5. abort asserted at RUN counter=10 → busy and stall_out low next cycle, no done pulse, result unchanged. Then a new start MUL 3*5 is accepted immediately → 15 after 34 cycles. start and abort together in IDLE → stays IDLE.
6. resetn pulled low mid-RUN → all outputs 0 asynchronously. start while busy (second op) ignored: first op's result returned, single done pulse.
